// File: rtl/sseg_pkg.sv
// Shared constants for the seven-segment display path.
// Glyphs are active-low, bit6..bit0 = a,b,c,d,e,f,g.
// No logic; constants only.
package sseg_pkg;

  // Segment bit positions within a 7-bit cathode word.
  localparam int SEG_BIT_A = 6;
  localparam int SEG_BIT_B = 5;
  localparam int SEG_BIT_C = 4;
  localparam int SEG_BIT_D = 3;
  localparam int SEG_BIT_E = 2;
  localparam int SEG_BIT_F = 1;
  localparam int SEG_BIT_G = 0;

  // All segments dark.
  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Digit glyphs 0..9.
  localparam logic [6:0] GLYPH_0 = 7'b0000001;
  localparam logic [6:0] GLYPH_1 = 7'b1001111;
  localparam logic [6:0] GLYPH_2 = 7'b0010010;
  localparam logic [6:0] GLYPH_3 = 7'b0000110;
  localparam logic [6:0] GLYPH_4 = 7'b1001100;
  localparam logic [6:0] GLYPH_5 = 7'b0100100;
  localparam logic [6:0] GLYPH_6 = 7'b0100000;
  localparam logic [6:0] GLYPH_7 = 7'b0001111;
  localparam logic [6:0] GLYPH_8 = 7'b0000000;
  localparam logic [6:0] GLYPH_9 = 7'b0000100;

  // Hex letter glyphs A..F.
  localparam logic [6:0] GLYPH_A = 7'b0001000;
  localparam logic [6:0] GLYPH_B = 7'b1100000;
  localparam logic [6:0] GLYPH_C = 7'b0110001;
  localparam logic [6:0] GLYPH_D = 7'b1000010;
  localparam logic [6:0] GLYPH_E = 7'b0110000;
  localparam logic [6:0] GLYPH_F = 7'b0111000;

endpackage

// File: rtl/seg_glyph.sv
// Combinational 4-bit code to active-low seven-segment glyph decoder.
// Latency: 0 cycles (pure combinational).
// No flow control; suppress or BCD codes 10-15 yield a dark glyph.
module seg_glyph
  import sseg_pkg::*;
(
  input  logic [3:0] code,
  input  logic       hex_mode,
  input  logic       suppress,
  output logic [6:0] glyph
);

  // Look up the glyph; letters only exist in hex mode.
  always_comb begin
    glyph = SEG_OFF;
    if (!suppress) begin
      case (code)
        4'h0: glyph = GLYPH_0;
        4'h1: glyph = GLYPH_1;
        4'h2: glyph = GLYPH_2;
        4'h3: glyph = GLYPH_3;
        4'h4: glyph = GLYPH_4;
        4'h5: glyph = GLYPH_5;
        4'h6: glyph = GLYPH_6;
        4'h7: glyph = GLYPH_7;
        4'h8: glyph = GLYPH_8;
        4'h9: glyph = GLYPH_9;
        4'hA: glyph = hex_mode ? GLYPH_A : SEG_OFF;
        4'hB: glyph = hex_mode ? GLYPH_B : SEG_OFF;
        4'hC: glyph = hex_mode ? GLYPH_C : SEG_OFF;
        4'hD: glyph = hex_mode ? GLYPH_D : SEG_OFF;
        4'hE: glyph = hex_mode ? GLYPH_E : SEG_OFF;
        4'hF: glyph = hex_mode ? GLYPH_F : SEG_OFF;
        default: glyph = SEG_OFF;
      endcase
    end
  end

endmodule

// File: rtl/sseg_scan_ctrl.sv
// N-digit seven-segment scan controller with blanking guard and frame snapshot.
// Latency: 1 cycle from (pre_cnt, idx, snapshot) to pins; snapshot lit BLANK_CYC+1 after capture.
// No backpressure; free-running scan, inputs sampled once per frame.
module sseg_scan_ctrl
  import sseg_pkg::*;
#(
  parameter int N_DIGITS    = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int BLANK_CYC   = 1000,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*N_DIGITS-1:0] digits_in,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic [N_DIGITS-1:0]   digit_en,
  input  logic                  hex_mode,
  input  logic                  lz_suppress,
  output logic [N_DIGITS-1:0]   an,
  output logic [6:0]            cath,
  output logic                  dp,
  output logic                  frame_start
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(N_DIGITS);
  localparam logic [PW-1:0] PRE_LAST  = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] PRE_BLANK = PW'(BLANK_CYC);
  localparam logic [IW-1:0] IDX_FIRST = IW'(N_DIGITS - 1);

  // Polarity mask: 1 when pins are active-high and internal levels must flip.
  localparam logic INV = (ACTIVE_LOW == 0);
  localparam logic [N_DIGITS-1:0] AN_OFF   = {N_DIGITS{~INV}};
  localparam logic [6:0]          CATH_OFF = SEG_OFF ^ {7{INV}};
  localparam logic                DP_OFF   = ~INV;

  logic [PW-1:0]         pre_cnt;
  logic [IW-1:0]         idx;
  logic [4*N_DIGITS-1:0] snap_digits;
  logic [N_DIGITS-1:0]   snap_dp;
  logic [N_DIGITS-1:0]   snap_en;
  logic                  snap_hex;
  logic                  snap_lz;

  logic                  capture;
  logic                  blank;
  logic                  zero_run;
  logic [N_DIGITS-1:0]   sup_mask;
  logic [3:0]            cur_code;
  logic                  cur_sup;
  logic [6:0]            cur_glyph;
  logic [N_DIGITS-1:0]   an_act;
  logic [6:0]            cath_low;
  logic                  dp_act;

  assign capture  = (pre_cnt == '0) && (idx == IDX_FIRST);
  assign blank    = (pre_cnt < PRE_BLANK);
  assign cur_code = snap_digits[{idx, 2'b00} +: 4];
  assign cur_sup  = sup_mask[idx];

  // Prescaler and slot index: leftmost digit first, stepping down each slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt <= '0;
      idx     <= IDX_FIRST;
    end else if (pre_cnt == PRE_LAST) begin
      pre_cnt <= '0;
      idx     <= (idx == '0) ? IDX_FIRST : idx - 1'b1;
    end else begin
      pre_cnt <= pre_cnt + 1'b1;
    end
  end

  // Frame-coherent snapshot of all display inputs at the start of each frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_digits <= '0;
      snap_dp     <= '0;
      snap_en     <= '0;
      snap_hex    <= 1'b0;
      snap_lz     <= 1'b0;
    end else if (capture) begin
      snap_digits <= digits_in;
      snap_dp     <= dp_in;
      snap_en     <= digit_en;
      snap_hex    <= hex_mode;
      snap_lz     <= lz_suppress;
    end
  end

  // Leading-zero mask: a digit stays suppressed while it and all digits left of it are bare zeros.
  always_comb begin
    zero_run = snap_lz;
    sup_mask = '0;
    for (int k = N_DIGITS - 1; k >= 1; k--) begin
      zero_run    = zero_run && (snap_digits[4*k +: 4] == 4'd0) && !snap_dp[k];
      sup_mask[k] = zero_run;
    end
  end

  seg_glyph u_glyph (
    .code     (cur_code),
    .hex_mode (snap_hex),
    .suppress (cur_sup),
    .glyph    (cur_glyph)
  );

  // Slot output in internal polarity: dark during the guard, else strobe the enabled anode.
  always_comb begin
    an_act   = '0;
    cath_low = SEG_OFF;
    dp_act   = 1'b0;
    if (!blank) begin
      an_act[idx] = snap_en[idx];
      cath_low    = cur_glyph;
      dp_act      = snap_dp[idx] & ~cur_sup;
    end
  end

  // Output registers with pin polarity applied.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an          <= AN_OFF;
      cath        <= CATH_OFF;
      dp          <= DP_OFF;
      frame_start <= 1'b0;
    end else begin
      an          <= an_act ^ AN_OFF;
      cath        <= cath_low ^ {7{INV}};
      dp          <= dp_act ^ DP_OFF;
      frame_start <= capture;
    end
  end

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Bench for sseg_scan_ctrl: N=4, REFRESH_DIV=8, BLANK_CYC=2, active-low pins.
// Timeline-based reference model checked every cycle, plus literal pin checks.
// Directed scenarios: reset, BCD, hex, suppression, coherence, enables.
module tb_sseg_scan_ctrl;

  localparam int N  = 4;
  localparam int RD = 8;
  localparam int BC = 2;
  localparam int FRAME = N * RD;

  localparam logic [6:0] GLY [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [15:0]  digits_in = '0;
  logic [3:0]   dp_in = '0;
  logic [3:0]   digit_en = '0;
  logic         hex_mode = 1'b0;
  logic         lz_suppress = 1'b0;
  logic [3:0]   an;
  logic [6:0]   cath;
  logic         dp;
  logic         frame_start;

  int errors = 0;
  int checks = 0;
  int cur_t  = 0;

  // Model's copy of the frame inputs, refreshed at each frame boundary.
  logic [15:0]  m_dig;
  logic [3:0]   m_dp;
  logic [3:0]   m_en;
  logic         m_hex;
  logic         m_lz;

  sseg_scan_ctrl #(
    .N_DIGITS    (N),
    .REFRESH_DIV (RD),
    .BLANK_CYC   (BC),
    .ACTIVE_LOW  (1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .digits_in   (digits_in),
    .dp_in       (dp_in),
    .digit_en    (digit_en),
    .hex_mode    (hex_mode),
    .lz_suppress (lz_suppress),
    .an          (an),
    .cath        (cath),
    .dp          (dp),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0d got %h expected %h", name, cur_t, act, exp);
    end
  endtask

  // Expected pins after cycle t of a frame timeline: {an, cath, dp, frame_start}.
  function automatic logic [12:0] model_out(input int t);
    int         pre   = t % RD;
    int         digit = N - 1 - ((t / RD) % N);
    logic       blank = (pre < BC);
    logic [3:0] an_e  = 4'hF;
    logic [6:0] c_e   = 7'h7F;
    logic       d_e   = 1'b1;
    logic [3:0] code;
    logic       sup;
    code = m_dig[4*digit +: 4];
    sup  = m_lz && (digit != 0);
    for (int j = digit; j < N; j++)
      if (m_dig[4*j +: 4] != 4'd0 || m_dp[j]) sup = 1'b0;
    if (!blank) begin
      if (m_en[digit]) an_e[digit] = 1'b0;
      if (!sup) begin
        c_e = (code > 4'd9 && !m_hex) ? 7'h7F : GLY[code];
        d_e = !m_dp[digit];
      end
    end
    return {an_e, c_e, d_e, (t % FRAME) == 0};
  endfunction

  // Compare process: every cycle, pins against the model (or the reset state).
  initial begin
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        cur_t = 0;
        m_dig = '0; m_dp = '0; m_en = '0; m_hex = 1'b0; m_lz = 1'b0;
        #1;
        chk("model_rst", {19'd0, an, cath, dp, frame_start}, {19'd0, 4'hF, 7'h7F, 1'b1, 1'b0});
      end else begin
        if (cur_t % FRAME == 0) begin
          m_dig = digits_in; m_dp = dp_in; m_en = digit_en;
          m_hex = hex_mode; m_lz = lz_suppress;
        end
        #1;
        chk("model", {19'd0, an, cath, dp, frame_start}, {19'd0, model_out(cur_t)});
        cur_t++;
      end
    end
  end

  // Return at the negedge where pins reflect timeline cycle t.
  task automatic wait_state(input int t);
    int n = 0;
    while (cur_t != t + 1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) chk("timeout", 32'd0, 32'd1);
  endtask

  task automatic lit(input string nm, input int t, input logic [3:0] an_e,
                     input logic [6:0] c_e, input logic d_e);
    wait_state(t);
    chk({nm, "_an"}, {28'd0, an}, {28'd0, an_e});
    chk({nm, "_cath"}, {25'd0, cath}, {25'd0, c_e});
    chk({nm, "_dp"}, {31'd0, dp}, {31'd0, d_e});
  endtask

  task automatic lit_fs(input string nm, input int t, input logic fs_e);
    wait_state(t);
    chk(nm, {31'd0, frame_start}, {31'd0, fs_e});
  endtask

  task automatic start(input logic [15:0] d, input logic [3:0] p, input logic [3:0] en,
                       input logic h, input logic lz);
    @(negedge clk);
    rst_n = 1'b0;
    digits_in = d; dp_in = p; digit_en = en; hex_mode = h; lz_suppress = lz;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    // BCD scan, frame pulse and blanking guard.
    start(16'h1234, 4'b0000, 4'b1111, 1'b0, 1'b0);
    lit_fs("fs_first", 0, 1'b1);
    lit("guard", 1, 4'b1111, 7'h7F, 1'b1);
    lit("bcd_d3", 2, 4'b0111, 7'b1001111, 1'b1);
    lit("bcd_d2", 10, 4'b1011, 7'b0010010, 1'b1);
    lit("bcd_d1", 18, 4'b1101, 7'b0000110, 1'b1);
    lit("bcd_d0", 26, 4'b1110, 7'b1001100, 1'b1);
    lit_fs("fs_gap", 31, 1'b0);
    lit_fs("fs_next", 32, 1'b1);

    // Reset asserted mid-slot takes effect without a clock edge.
    wait_state(44);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_an", {28'd0, an}, 32'hF);
    chk("arst_cath", {25'd0, cath}, 32'h7F);
    chk("arst_dp", {31'd0, dp}, 32'd1);
    chk("arst_fs", {31'd0, frame_start}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    lit("post_rst", 2, 4'b0111, 7'b1001111, 1'b1);

    // Input change mid-frame is deferred to the next frame.
    wait_state(17);
    digits_in = 16'h5678;
    lit("coh_d1", 18, 4'b1101, 7'b0000110, 1'b1);
    lit("coh_d0", 26, 4'b1110, 7'b1001100, 1'b1);
    lit_fs("coh_fs", 32, 1'b1);
    lit("coh_new_d3", 34, 4'b0111, 7'b0100100, 1'b1);
    lit("coh_new_d2", 42, 4'b1011, 7'b0100000, 1'b1);

    // Hex glyphs.
    start(16'hA0F9, 4'b0000, 4'b1111, 1'b1, 1'b0);
    lit("hex_d3", 2, 4'b0111, 7'b0001000, 1'b1);
    lit("hex_d2", 10, 4'b1011, 7'b0000001, 1'b1);
    lit("hex_d1", 18, 4'b1101, 7'b0111000, 1'b1);
    lit("hex_d0", 26, 4'b1110, 7'b0000100, 1'b1);

    // BCD mode with non-decimal codes: dark glyph, anode still strobed.
    start(16'hA0F9, 4'b0000, 4'b1111, 1'b0, 1'b0);
    lit("bcdx_d3", 2, 4'b0111, 7'h7F, 1'b1);
    lit("bcdx_d1", 18, 4'b1101, 7'h7F, 1'b1);
    lit("bcdx_d0", 26, 4'b1110, 7'b0000100, 1'b1);

    // Leading-zero suppression.
    start(16'h0050, 4'b0000, 4'b1111, 1'b0, 1'b1);
    lit("lz_d3", 2, 4'b0111, 7'h7F, 1'b1);
    lit("lz_d2", 10, 4'b1011, 7'h7F, 1'b1);
    lit("lz_d1", 18, 4'b1101, 7'b0100100, 1'b1);
    lit("lz_d0", 26, 4'b1110, 7'b0000001, 1'b1);

    start(16'h0000, 4'b0000, 4'b1111, 1'b0, 1'b1);
    lit("lz0_d3", 2, 4'b0111, 7'h7F, 1'b1);
    lit("lz0_d1", 18, 4'b1101, 7'h7F, 1'b1);
    lit("lz0_d0", 26, 4'b1110, 7'b0000001, 1'b1);

    // A decimal point stops suppression at its digit.
    start(16'h0000, 4'b0100, 4'b1111, 1'b0, 1'b1);
    lit("lzdp_d3", 2, 4'b0111, 7'h7F, 1'b1);
    lit("lzdp_d2", 10, 4'b1011, 7'b0000001, 1'b0);
    lit("lzdp_d1", 18, 4'b1101, 7'b0000001, 1'b1);

    // Per-digit enables: disabled slots still elapse.
    start(16'h1234, 4'b0000, 4'b1010, 1'b0, 1'b0);
    lit("en_d3", 2, 4'b0111, 7'b1001111, 1'b1);
    lit("en_d2", 10, 4'b1111, 7'b0010010, 1'b1);
    lit("en_d1", 18, 4'b1101, 7'b0000110, 1'b1);
    lit("en_d0", 26, 4'b1111, 7'b1001100, 1'b1);
    lit_fs("en_fs", 32, 1'b1);
    lit("en_f2_d1", 50, 4'b1101, 7'b0000110, 1'b1);
    wait_state(64);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sseg_scan_ctrl.md
# sseg_scan_ctrl

Parametrised N-digit seven-segment scan controller for the board display path. It time-multiplexes `N_DIGITS` 4-bit digit codes onto a shared cathode bus with per-slot anode strobing, and inserts a blanking guard at each slot start to prevent ghosting. It also provides BCD/hex glyph modes, leading-zero suppression, decimal points, per-digit enables, and a frame-coherent input snapshot. It sits between the datapath's value registers and the board pins, and replaces the fixed 4-digit multiplexer/decoder pair.

## Interface
- `N_DIGITS`, 4: number of digits; ≥2.
- `REFRESH_DIV`, 50000: `clk` cycles per digit slot; ≥2.
- `BLANK_CYC`, 1000: blanked cycles at the start of each slot; 1 ≤ `BLANK_CYC` < `REFRESH_DIV`.
- `ACTIVE_LOW`, 1: 1 means `an`/`cath`/`dp` are active-low; 0 inverts all three.
- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `digits_in` in 4*`N_DIGITS`: digit codes; digit k at [4k+3:4k]; digit `N_DIGITS-1` is leftmost.
- `dp_in` in `N_DIGITS`: decimal point request per digit.
- `digit_en` in `N_DIGITS`: 0 means the digit's anode is never driven (its slot still elapses).
- `hex_mode` in 1: 1 selects hex glyphs, 0 selects BCD.
- `lz_suppress` in 1: enables leading-zero suppression.
- `an` out `N_DIGITS`: anode strobes, one-hot active or all inactive.
- `cath` out 7: segments, bit6..bit0 = a,b,c,d,e,f,g.
- `dp` out 1: decimal point segment.
- `frame_start` out 1: one-cycle pulse when a new input snapshot has been captured.

## Operation
- Prescaler `pre_cnt` counts 0..`REFRESH_DIV`-1.
  - At the terminal count it wraps to 0 and the slot index `idx` steps down: `N_DIGITS-1` → … → 0 → `N_DIGITS-1`. Scan order is leftmost first.
- Snapshot: in the cycle where `pre_cnt`==0 and `idx`==`N_DIGITS-1`, register `digits_in`, `dp_in`, `digit_en`, `hex_mode` and `lz_suppress`.
  - This includes the first cycle after reset release.
  - All display decisions use only the snapshot, so input changes mid-frame never tear the display.
- Slot output, with inactive levels as given under Reset values:
  - While `pre_cnt` < `BLANK_CYC`: all outputs inactive.
  - Otherwise: `an` asserts bit `idx` if snapshot `digit_en[idx]`==1, else stays inactive.
- Glyphs, written for `ACTIVE_LOW`=1:
  - 0–9: 0000001, 1001111, 0010010, 0000110, 1001100, 0100100, 0100000, 0001111, 0000000, 0000100.
  - Hex mode, A–F: 0001000, 1100000, 0110001, 1000010, 0110000, 0111000.
  - BCD mode, codes 10–15: `cath` all off, anode still strobed.
- Leading-zero suppression, when the snapshot `lz_suppress`==1:
  - Scanning from digit `N_DIGITS-1` downward, a digit is suppressed (`cath` off, `dp` off) while every digit above it and itself is code 0 with `dp_in`==0.
  - Digit 0 is never suppressed.
- `dp` is active when the snapshot `dp_in[idx]`==1 and the digit is neither blanked nor suppressed.

## Timing
- `an`, `cath`, `dp` and `frame_start` are registered. Each reflects the (`pre_cnt`, `idx`, snapshot) state of the previous cycle.
  - Latency: the snapshot is visible on pins at the first unblanked cycle of slot `N_DIGITS-1`, at output cycle `BLANK_CYC`+1 after capture.
- Per slot: `BLANK_CYC` cycles dark, then `REFRESH_DIV-BLANK_CYC` cycles lit. Frame period = `N_DIGITS*REFRESH_DIV` cycles.
- `frame_start` is high for exactly one cycle, the cycle after capture, once per frame.
- Reset values, asserted asynchronously and held while `rst_n`=0:
  - `pre_cnt`=0, `idx`=`N_DIGITS-1`, snapshot=0.
  - `an` all inactive, `cath`=7'h7F, `dp`=1 (for `ACTIVE_LOW`=1), `frame_start`=0.
- Reset mid-slot: outputs go inactive immediately. After release, scan restarts from digit `N_DIGITS-1` with a fresh snapshot.
- Counter widths: `$clog2(REFRESH_DIV)` and `$clog2(N_DIGITS)`. Indices wrap with no out-of-range states.

## Structure
- `sseg_pkg`: segment glyph constants 0–F, `SEG_OFF`=7'h7F, segment bit-order localparams.
- Sub-module `seg_glyph`: combinational decoder taking code, `hex_mode` and suppress, and producing the 7-bit active-low glyph. It is instantiated once on the selected digit.
- The top level holds the prescaler, slot index, snapshot registers, suppression mask, polarity inversion and output registers.

## Test plan
All scenarios use `N_DIGITS`=4, `REFRESH_DIV`=8, `BLANK_CYC`=2.
- Reset: pull `rst_n` low mid-slot → asynchronously `an`=1111, `cath`=7F, `dp`=1, `frame_start`=0. After release, the first lit slot is `an`=0111.
- BCD scan: `digits_in`=16'h1234, all enabled → `an` 0111/1011/1101/1110 each lit 6 cycles after 2 dark. `cath` = 1001111, 0010010, 0000110, 1001100. `frame_start` every 32 cycles.
- Modes: 16'hA0F9 with `hex_mode`=1 → `cath` 0001000, 0000001, 0111000, 0000100. With `hex_mode`=0 → digits 3 and 1 `cath`=7F with anode strobed.
- Suppression: 16'h0050 with `lz_suppress`=1 → digits 3 and 2 `cath`=7F; digits 1 and 0 show 5 and 0. 16'h0000 → only digit 0 shows 0. 16'h0000 with `dp_in`=0100 → digit 2 shows 0 with `dp`=0.
- Coherence: change `digits_in` from 1234 to 5678 during slot 1 → slots 1 and 0 still show 3 and 4. 5678 appears starting the frame after the next `frame_start`.
- Enables: `digit_en`=1010 → `an` only ever 0111 or 1101. Slot timing is unchanged, with 32-cycle frames.
